// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: streams a 128-bit AES state byte-by-byte through one shared InvSubBytes S-box.
// Defining INV_SUB_BYTES_SEQ_ABORT_EN adds an abort input that returns a busy block to IDLE.
module inv_sub_bytes_seq #(
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
`ifdef INV_SUB_BYTES_SEQ_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [127:0] data;
    logic [3:0] iss_cnt, cap_cnt, iss_nxt;
    logic [SBOX_LAT-1:0] pipe;
    logic kill, accept, capture, last_cap;
`ifdef INV_SUB_BYTES_SEQ_ABORT_EN
    assign kill = abort && state != IDLE;
`else
    assign kill = 1'b0;
`endif
    assign accept    = in_valid && state == IDLE;
    assign capture   = pipe[SBOX_LAT-1];
    assign last_cap  = capture && cap_cnt == 4'd15;
    assign iss_nxt   = iss_cnt + 4'd1;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (kill) state_nxt = IDLE;
        else
            case (state)
                IDLE:    if (in_valid) state_nxt = ISSUE;
                ISSUE:   if (iss_cnt == 4'd15) state_nxt = DRAIN;
                DRAIN:   if (last_cap) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
    end
    // byte k lives at bit offset 8*(15-k), i.e. {~k, 3'b000}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= '0;
            iss_cnt   <= '0;
            cap_cnt   <= '0;
            pipe      <= '0;
            sbox_in   <= '0;
            out_state <= '0;
        end else if (kill) begin
            iss_cnt <= '0;
            cap_cnt <= '0;
            pipe    <= '0;
        end else begin
            pipe <= SBOX_LAT'({pipe, state == ISSUE});
            if (accept) begin
                data    <= in_state;
                iss_cnt <= '0;
                cap_cnt <= '0;
                sbox_in <= in_state[127:120];
            end
            if (state == ISSUE) begin
                iss_cnt <= iss_nxt;
                if (iss_cnt != 4'd15) sbox_in <= data[{~iss_nxt, 3'b000} +: 8];
            end
            if (capture) begin
                out_state[{~cap_cnt, 3'b000} +: 8] <= sbox_out;
                cap_cnt <= cap_cnt + 4'd1;
            end
        end
    end
endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Byte-serial controller that shares one 8-bit InvSubBytes S-box across a full 128-bit AES state for the area-optimised decrypt path.
- Accepts a 128-bit state over a valid/ready handshake and streams its 16 bytes through the external S-box, one per cycle.
- Collects the substituted bytes in order and returns the 128-bit result over a second valid/ready handshake.
- Sits between the decrypt round controller and the shared InvSubBytes instance.

Parameters:
- SBOX_LAT, 1, clock cycles from sbox_in being driven to the matching sbox_out; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a new state
- in_state  input  128  state to substitute; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  output  1  out_state holds a complete result
- out_ready  input  1  consumer accepts out_state
- out_state  output  128  substituted state, same byte order as in_state
- sbox_in  output  8  byte driven to the shared InvSubBytes state input
- sbox_out  input  8  InvSubBytes result (Sstate), SBOX_LAT cycles after sbox_in
- busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs and registers reset asynchronously when rst=1, taking effect immediately:
  - state IDLE, in_ready=1, out_valid=0, out_state=0, sbox_in=0, busy=0, counters=0.
- State machine states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at the edge ending cycle T: latch in_state, clear iss_cnt and cap_cnt, go to ISSUE.
- ISSUE:
  - sbox_in is registered and equals byte iss_cnt during cycle T+1+iss_cnt.
  - iss_cnt increments by 1 each cycle, 4 bits wide.
  - After byte 15 is issued, go to DRAIN.
- Capture:
  - A SBOX_LAT-deep valid shift pipe tracks issued bytes.
  - When the pipe output is 1, sbox_out is written to out_state byte cap_cnt at the end of that cycle, and cap_cnt increments.
  - Byte k is captured at the end of cycle T+1+k+SBOX_LAT.
  - Capture runs in both ISSUE and DRAIN.
- DRAIN:
  - sbox_in holds its last value.
  - When the capture of byte 15 occurs, go to DONE.
- DONE:
  - out_valid=1 and out_state is stable.
  - First out_valid cycle is T+17+SBOX_LAT, i.e. T+18 at default.
  - When out_ready=1, at that edge: out_valid goes to 0, state goes to IDLE, in_ready goes to 1 from the next cycle.
  - out_valid never drops without out_ready.
- in_ready=0 in ISSUE, DRAIN and DONE, so no new input is accepted while a result is pending. Throughput is one state per 18+SBOX_LAT cycles minimum.
- in_valid during a busy state is ignored, not queued; the upstream holds it.
- Counter wrap: iss_cnt and cap_cnt wrap 15->0 only at job end; no partial jobs exist.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-operation: rst at any cycle aborts the job; there is no partial output and sbox_out is ignored after reset.
- No arithmetic beyond the counters; out_state bytes are written only by capture.

Optional Feature:
- Macro: INV_SUB_BYTES_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in ISSUE, DRAIN or DONE returns the block to IDLE at the next edge.
  - out_valid is forced to 0, counters clear, the capture pipe flushes, and out_state is retained but must be treated as invalid.
  - abort in IDLE is a no-op.
  - abort has priority over in_valid and out_ready in the same cycle.
- When undefined: no abort port; a job can only end via DONE handshake or rst.

Test Plan:
- Reset check: rst pulse mid-cycle -> in_ready=1, out_valid=0, out_state=0 immediately, without waiting for a clock edge.
- Single job, SBOX_LAT=1:
  - in_state=128'h00010203_04050607_08090a0b_0c0dff4f, accepted at cycle T, out_ready=1.
  - out_valid first at T+18.
  - out_state = 52096ad5_3036a538_bf40a39e_81f37d92.
  - sbox_in = 00,01,02,...,ff,4f on cycles T+1..T+16.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_state held stable, in_ready=0, and a second in_valid is not accepted until the cycle after the out_ready handshake.
- Latency sweep, SBOX_LAT=3 with a delay-line S-box model:
  - in_state = all bytes 8'h63.
  - out_state = all 8'h00; out_valid first at T+20.
- Reset mid-ISSUE: assert rst at cycle T+7 -> IDLE, no out_valid afterwards. A following job with all bytes 8'h4f yields all 8'h92.
- With INV_SUB_BYTES_SEQ_ABORT_EN:
  - abort at T+10 -> IDLE at T+11.
  - abort and out_ready together in DONE -> out_valid drops and no handshake is counted.
